// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline controller: FSM states, register-number width, stage indices.
package pipeline_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        DRAIN,
        HALTED
    } ctrl_state_t;

    typedef enum logic [2:0] {
        STG_F,
        STG_D,
        STG_E,
        STG_M,
        STG_W
    } stage_t;

endpackage

// File: rtl/pipeline_hazard_detect.sv
// Load-use detector: the load in E produces a register that the instruction in D reads.
module pipeline_hazard_detect
    import pipeline_pkg::*;
(
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic             d_use_rs,
    input  logic             d_use_rt,
    input  logic             e_wreg,
    input  logic             e_m2reg,
    input  logic [REG_W-1:0] e_rn,
    output logic             load_use
);

    // r0 is hardwired, so a load targeting it never creates a dependency
    assign load_use = e_m2reg & e_wreg & (e_rn != '0) &
                      ((d_use_rs & (d_rs == e_rn)) | (d_use_rt & (d_rt == e_rn)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/bubble controller with memory-wait, flush, load-use and drain/halt handling.
// Define PIPELINE_CTRL_PERF_EN to add the stall-cycle and flush-event performance counters.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 255,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic             d_use_rs,
    input  logic             d_use_rt,
    input  logic             e_wreg,
    input  logic             e_m2reg,
    input  logic [REG_W-1:0] e_rn,
    input  logic             m_jmp_taken,
    input  logic             m_mem_req,
    input  logic             m_mem_ready,
    input  logic             halt_req,
    output logic             f_stall,
    output logic             d_stall,
    output logic             e_stall,
    output logic             m_stall,
    output logic             d_bubble,
    output logic             e_bubble,
    output logic             m_bubble,
    output logic             w_bubble,
    output logic             halt_ack,
    output logic             mem_timeout
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_stall_cycles,
    output logic [31:0]      perf_flush_count
`endif
);

    ctrl_state_t state;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_nxt;
    logic [2:0]  drain_cnt;
    logic        mw_q;
    logic        load_use;
    logic        mem_wait;
    logic        flush;
    logic        lu_act;
    logic        drain_step;

    pipeline_hazard_detect u_hazard (
        .d_rs     (d_rs),
        .d_rt     (d_rt),
        .d_use_rs (d_use_rs),
        .d_use_rt (d_use_rt),
        .e_wreg   (e_wreg),
        .e_m2reg  (e_m2reg),
        .e_rn     (e_rn),
        .load_use (load_use)
    );

    // A halted pipeline is frozen, so M-stage events are ignored there
    assign mem_wait   = m_mem_req & ~m_mem_ready & (state != HALTED);
    assign flush      = m_jmp_taken & ~mem_wait & (state != HALTED);
    assign lu_act     = load_use & ~flush & ~mem_wait & (state != HALTED);
    // Load-use stalls in DRAIN hold D, so those cycles do not advance the drain
    assign drain_step = (state == DRAIN) & ~mem_wait & ~lu_act;
    assign wait_nxt   = !mw_q ? 8'd0 : ((wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1);

    always_comb begin
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        e_stall  = 1'b0;
        m_stall  = 1'b0;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        m_bubble = 1'b0;
        w_bubble = 1'b0;
        if (reset) begin
            d_bubble = 1'b1;
            e_bubble = 1'b1;
            m_bubble = 1'b1;
            w_bubble = 1'b1;
        end else if (state == HALTED) begin
            f_stall = 1'b1;
            d_stall = 1'b1;
            e_stall = 1'b1;
            m_stall = 1'b1;
        end else if (mem_wait) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_stall  = 1'b1;
            m_stall  = 1'b1;
            w_bubble = 1'b1;
        end else if (flush) begin
            f_stall  = (state == DRAIN);
            d_bubble = 1'b1;
            e_bubble = 1'b1;
            m_bubble = 1'b1;
        end else if (lu_act) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_bubble = 1'b1;
        end else if (state == DRAIN) begin
            f_stall  = 1'b1;
            d_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            drain_cnt   <= '0;
            mw_q        <= 1'b0;
            halt_ack    <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            mw_q <= mem_wait;
            if (mem_wait) begin
                wait_cnt <= wait_nxt;
                if (wait_nxt >= 8'(MEM_TIMEOUT))
                    mem_timeout <= 1'b1;
            end
            case (state)
                RUN: begin
                    if (mem_wait)
                        state <= MEM_WAIT;
                    else if (halt_req) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_wait)
                        state <= RUN;
                end
                DRAIN: begin
                    if (drain_step) begin
                        if (drain_cnt == 3'(DRAIN_CYCLES - 1)) begin
                            state    <= HALTED;
                            halt_ack <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 3'd1;
                        end
                    end
                end
                HALTED: begin
                    if (!halt_req) begin
                        state    <= RUN;
                        halt_ack <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (f_stall | d_stall | e_stall | m_stall)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (flush)
                perf_flush_count <= perf_flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl (MEM_TIMEOUT=2, DRAIN_CYCLES=4).
module tb_pipeline_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs, d_rt, e_rn;
    logic       d_use_rs, d_use_rt, e_wreg, e_m2reg;
    logic       m_jmp_taken, m_mem_req, m_mem_ready, halt_req;
    logic       f_stall, d_stall, e_stall, m_stall;
    logic       d_bubble, e_bubble, m_bubble, w_bubble;
    logic       halt_ack, mem_timeout;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_count;
`endif
    logic [7:0] outv;
    int         total;
    int         passed;

    assign outv = {f_stall, d_stall, e_stall, m_stall, d_bubble, e_bubble, m_bubble, w_bubble};

    pipeline_ctrl #(.MEM_TIMEOUT(2), .DRAIN_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_use_rs    (d_use_rs),
        .d_use_rt    (d_use_rt),
        .e_wreg      (e_wreg),
        .e_m2reg     (e_m2reg),
        .e_rn        (e_rn),
        .m_jmp_taken (m_jmp_taken),
        .m_mem_req   (m_mem_req),
        .m_mem_ready (m_mem_ready),
        .halt_req    (halt_req),
        .f_stall     (f_stall),
        .d_stall     (d_stall),
        .e_stall     (e_stall),
        .m_stall     (m_stall),
        .d_bubble    (d_bubble),
        .e_bubble    (e_bubble),
        .m_bubble    (m_bubble),
        .w_bubble    (w_bubble),
        .halt_ack    (halt_ack),
        .mem_timeout (mem_timeout)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        d_rs = '0; d_rt = '0; e_rn = '0;
        d_use_rs = 0; d_use_rt = 0; e_wreg = 0; e_m2reg = 0;
        m_jmp_taken = 0; m_mem_req = 0; m_mem_ready = 0; halt_req = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        settle();
        total++; if (outv !== 8'b0000_1111) $display("FAIL rst_out: got %b want %b", outv, 8'b00001111); else passed++;
        total++; if (halt_ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", halt_ack); else passed++;
        next_cycle();
        reset = 1'b0;
        settle();
        total++; if (outv !== 8'b0) $display("FAIL idle_out: got %b want 00000000", outv); else passed++;
        total++; if (mem_timeout !== 1'b0) $display("FAIL idle_tmo: got %b want 0", mem_timeout); else passed++;
        next_cycle();
    endtask

    task automatic test_load_use();
        e_m2reg = 1; e_wreg = 1; e_rn = 5'd8; d_use_rs = 1; d_rs = 5'd8;
        settle();
        total++; if (outv !== 8'b1100_0100) $display("FAIL lu_rs: got %b want %b", outv, 8'b11000100); else passed++;
        next_cycle();
        clear_inputs();
        settle();
        total++; if (outv !== 8'b0) $display("FAIL lu_once: got %b want 00000000", outv); else passed++;
        next_cycle();
        e_m2reg = 1; e_wreg = 1; e_rn = 5'd0; d_use_rs = 1; d_rs = 5'd0;
        settle();
        total++; if (outv !== 8'b0) $display("FAIL lu_r0: got %b want 00000000", outv); else passed++;
        next_cycle();
        clear_inputs();
        e_m2reg = 1; e_wreg = 1; e_rn = 5'd5; d_use_rt = 1; d_rt = 5'd5; d_rs = 5'd3; d_use_rs = 1;
        settle();
        total++; if (outv !== 8'b1100_0100) $display("FAIL lu_rt: got %b want %b", outv, 8'b11000100); else passed++;
        next_cycle();
        clear_inputs();
        e_m2reg = 1; e_wreg = 1; e_rn = 5'd8; d_use_rs = 0; d_rs = 5'd8;
        settle();
        total++; if (outv !== 8'b0) $display("FAIL lu_nouse: got %b want 00000000", outv); else passed++;
        next_cycle();
        clear_inputs();
        e_m2reg = 0; e_wreg = 1; e_rn = 5'd8; d_use_rs = 1; d_rs = 5'd8;
        settle();
        total++; if (outv !== 8'b0) $display("FAIL lu_noload: got %b want 00000000", outv); else passed++;
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_flush();
        m_jmp_taken = 1;
        settle();
        total++; if (outv !== 8'b0000_1110) $display("FAIL flush: got %b want %b", outv, 8'b00001110); else passed++;
        next_cycle();
        e_m2reg = 1; e_wreg = 1; e_rn = 5'd8; d_use_rs = 1; d_rs = 5'd8;
        settle();
        total++; if (outv !== 8'b0000_1110) $display("FAIL flush_lu: got %b want %b", outv, 8'b00001110); else passed++;
        next_cycle();
        clear_inputs();
        settle();
        total++; if (outv !== 8'b0) $display("FAIL flush_end: got %b want 00000000", outv); else passed++;
        next_cycle();
    endtask

    task automatic test_mem_wait();
        m_mem_req = 1; m_mem_ready = 0; m_jmp_taken = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            total++; if (outv !== 8'b1111_0001) $display("FAIL memwait_%0d: got %b want %b", i, outv, 8'b11110001); else passed++;
            if (i == 1) begin
                total++; if (mem_timeout !== 1'b0) $display("FAIL tmo_early: got %b want 0", mem_timeout); else passed++;
            end
            next_cycle();
        end
        m_mem_ready = 1;
        settle();
        total++; if (outv !== 8'b0000_1110) $display("FAIL mem_flush: got %b want %b", outv, 8'b00001110); else passed++;
        total++; if (mem_timeout !== 1'b1) $display("FAIL tmo_set: got %b want 1", mem_timeout); else passed++;
        next_cycle();
        clear_inputs();
        settle();
        total++; if (outv !== 8'b0) $display("FAIL mem_run: got %b want 00000000", outv); else passed++;
        next_cycle();
        settle();
        total++; if (mem_timeout !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", mem_timeout); else passed++;
        next_cycle();
    endtask

    task automatic test_halt();
        halt_req = 1;
        settle();
        total++; if (outv !== 8'b0) $display("FAIL halt_req_cyc: got %b want 00000000", outv); else passed++;
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            settle();
            total++; if (outv !== 8'b1000_1000) $display("FAIL drain_%0d: got %b want %b", i, outv, 8'b10001000); else passed++;
            total++; if (halt_ack !== 1'b0) $display("FAIL drain_ack_%0d: got %b want 0", i, halt_ack); else passed++;
            next_cycle();
        end
        settle();
        total++; if (outv !== 8'b1111_0000) $display("FAIL halted: got %b want %b", outv, 8'b11110000); else passed++;
        total++; if (halt_ack !== 1'b1) $display("FAIL halted_ack: got %b want 1", halt_ack); else passed++;
        next_cycle();
        halt_req = 0;
        settle();
        total++; if (outv !== 8'b1111_0000) $display("FAIL halted_rel: got %b want %b", outv, 8'b11110000); else passed++;
        next_cycle();
        settle();
        total++; if (outv !== 8'b0) $display("FAIL resume: got %b want 00000000", outv); else passed++;
        total++; if (halt_ack !== 1'b0) $display("FAIL resume_ack: got %b want 0", halt_ack); else passed++;
        next_cycle();
    endtask

    task automatic test_drain_pause();
        halt_req = 1;
        next_cycle();
        settle();
        total++; if (outv !== 8'b1000_1000) $display("FAIL dp_first: got %b want %b", outv, 8'b10001000); else passed++;
        next_cycle();
        m_mem_req = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++; if (outv !== 8'b1111_0001) $display("FAIL dp_wait_%0d: got %b want %b", i, outv, 8'b11110001); else passed++;
            next_cycle();
        end
        m_mem_req = 0; halt_req = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            total++; if (outv !== 8'b1000_1000) $display("FAIL dp_rest_%0d: got %b want %b", i, outv, 8'b10001000); else passed++;
            next_cycle();
        end
        settle();
        total++; if (halt_ack !== 1'b1) $display("FAIL dp_ack: got %b want 1", halt_ack); else passed++;
        next_cycle();
        settle();
        total++; if (halt_ack !== 1'b0) $display("FAIL dp_resume: got %b want 0", halt_ack); else passed++;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        halt_req = 1;
        next_cycle();
        settle();
        total++; if (mem_timeout !== 1'b1) $display("FAIL tmo_keep: got %b want 1", mem_timeout); else passed++;
        next_cycle();
        reset = 1;
        settle();
        total++; if (outv !== 8'b0000_1111) $display("FAIL rst_drain: got %b want %b", outv, 8'b00001111); else passed++;
        next_cycle();
        settle();
        total++; if (halt_ack !== 1'b0) $display("FAIL rst_drain_ack: got %b want 0", halt_ack); else passed++;
        total++; if (mem_timeout !== 1'b0) $display("FAIL rst_tmo: got %b want 0", mem_timeout); else passed++;
`ifdef PIPELINE_CTRL_PERF_EN
        total++; if (perf_stall_cycles !== 32'd0) $display("FAIL rst_perf_stall: got %0d want 0", perf_stall_cycles); else passed++;
        total++; if (perf_flush_count !== 32'd0) $display("FAIL rst_perf_flush: got %0d want 0", perf_flush_count); else passed++;
`endif
        next_cycle();
        reset = 0; halt_req = 0; m_mem_req = 1;
        next_cycle();
        reset = 1;
        settle();
        total++; if (outv !== 8'b0000_1111) $display("FAIL rst_memwait: got %b want %b", outv, 8'b00001111); else passed++;
        next_cycle();
        reset = 0; m_mem_req = 0;
        settle();
        total++; if (outv !== 8'b0) $display("FAIL rst_after: got %b want 00000000", outv); else passed++;
        next_cycle();
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_load_use();
        test_flush();
        test_mem_wait();
        test_halt();
        test_drain_pause();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
